// File: rtl/plb_cache_responder.sv
// plb_cache_responder
// Memory-slave end of the PLB cache port. Holds a small fully-associative
// store of lookup tags and answers every granted request one cycle later.
// Lookups return a 1-bit hit; inserts fill the lowest invalid slot or,
// when the store is full, overwrite a round-robin victim. A flush empties
// the store. Saturating hit/miss counters feed performance monitoring.
//
// Handshake: a request is accepted (gnt=1) in any cycle where req=1 and no
// flush is asserted; there is no other back-pressure. Every accepted
// request produces exactly one valid pulse in the following cycle,
// unconditionally and in order; the master must always be able to take it.

package plb_cache_responder_pkg;
    // Lookup request issued by the walker's PLB stage; the whole request
    // is used as the tag.
    typedef struct packed {
        logic [19:0] vpn;
        logic [11:0] ptid;
    } plb_lookup_req_t;
endpackage

module plb_cache_responder #(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = $bits(plb_cache_responder_pkg::plb_lookup_req_t),
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  plb_cache_mem_req,
    output logic                  plb_cache_mem_gnt,
    input  logic [ADDR_WIDTH-1:0] plb_cache_mem_addr,
    input  logic                  plb_cache_mem_we,
    output logic                  plb_cache_mem_valid,
    output logic                  plb_cache_mem_rdata,
    input  logic                  plb_flush_i,
    output logic [CNT_WIDTH-1:0]  plb_hit_count_o,
    output logic [CNT_WIDTH-1:0]  plb_miss_count_o
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    // Store contents
    logic [ADDR_WIDTH-1:0] r_tag [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_vld;
    logic [IDX_W-1:0]       r_victim;

    // Response pipeline
    logic                   r_rsp_valid;
    logic                   r_rsp_hit;

    // Performance counters
    logic [CNT_WIDTH-1:0]   r_hit_cnt;
    logic [CNT_WIDTH-1:0]   r_miss_cnt;

    // Combinational decode
    logic                   w_gnt;
    logic                   w_lookup;
    logic                   w_insert;
    logic [NUM_ENTRIES-1:0] w_match;
    logic                   w_hit;
    logic                   w_has_free;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_do_write;
    logic [IDX_W-1:0]       w_write_idx;

    // Flush blocks the grant; it is the only source of back-pressure.
    assign w_gnt    = plb_cache_mem_req && !plb_flush_i;
    assign w_lookup = w_gnt && !plb_cache_mem_we;
    assign w_insert = w_gnt &&  plb_cache_mem_we;

    // Parallel tag compare against every valid entry.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_match[i] = r_vld[i] && (r_tag[i] == plb_cache_mem_addr);
        end
    end

    assign w_hit = |w_match;

    // Lowest-index invalid entry; scanning downward leaves the lowest winner.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // An insert of a tag already present is a no-op, so no duplicates form.
    always_comb begin
        w_do_write  = w_insert && !w_hit;
        w_write_idx = w_has_free ? w_free_idx : r_victim;
    end

    // Valid bits and victim pointer; flush clears both.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vld    <= '0;
            r_victim <= '0;
        end else if (plb_flush_i) begin
            r_vld    <= '0;
            r_victim <= '0;
        end else if (w_do_write) begin
            r_vld[w_write_idx] <= 1'b1;
            if (!w_has_free) begin
                // Power-of-two entry count: natural overflow wraps to 0.
                r_victim <= r_victim + IDX_W'(1);
            end
        end
    end

    // Tag payload; contents are qualified by r_vld so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (w_do_write && !plb_flush_i) begin
            r_tag[w_write_idx] <= plb_cache_mem_addr;
        end
    end

    // One-cycle response register; reset drops any pending response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
        end else begin
            r_rsp_valid <= w_gnt;
            r_rsp_hit   <= w_lookup && w_hit;
        end
    end

    // Saturating hit/miss counters, updated alongside the response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_lookup) begin
            if (w_hit) begin
                if (r_hit_cnt != '1) begin
                    r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
                end
            end else begin
                if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign plb_cache_mem_gnt   = w_gnt;
    assign plb_cache_mem_valid = r_rsp_valid;
    assign plb_cache_mem_rdata = r_rsp_valid && r_rsp_hit;
    assign plb_hit_count_o     = r_hit_cnt;
    assign plb_miss_count_o    = r_miss_cnt;

endmodule

// File: tb/tb_plb_cache_responder.sv
// tb_plb_cache_responder
// Directed scenarios followed by randomized traffic, checked against a
// slot-level behavioural model of the tag store and counters.

module tb_plb_cache_responder;

    localparam int NE = 8;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_ni;
    logic          plb_cache_mem_req;
    logic          plb_cache_mem_gnt;
    logic [AW-1:0] plb_cache_mem_addr;
    logic          plb_cache_mem_we;
    logic          plb_cache_mem_valid;
    logic          plb_cache_mem_rdata;
    logic          plb_flush_i;
    logic [CW-1:0] plb_hit_count_o;
    logic [CW-1:0] plb_miss_count_o;

    plb_cache_responder #(
        .NUM_ENTRIES(NE),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .plb_cache_mem_req  (plb_cache_mem_req),
        .plb_cache_mem_gnt  (plb_cache_mem_gnt),
        .plb_cache_mem_addr (plb_cache_mem_addr),
        .plb_cache_mem_we   (plb_cache_mem_we),
        .plb_cache_mem_valid(plb_cache_mem_valid),
        .plb_cache_mem_rdata(plb_cache_mem_rdata),
        .plb_flush_i        (plb_flush_i),
        .plb_hit_count_o    (plb_hit_count_o),
        .plb_miss_count_o   (plb_miss_count_o)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];   // {valid, rdata} expected in the next cycle

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [AW-1:0] m_tag[NE];
    bit            m_vld[NE];
    int            m_victim;
    int            m_hits;
    int            m_miss;

    function automatic bit m_present(input logic [AW-1:0] a);
        for (int i = 0; i < NE; i++) begin
            if (m_vld[i] && m_tag[i] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NE; i++) m_vld[i] = 1'b0;
        m_victim = 0;
    endfunction

    function automatic void m_insert(input logic [AW-1:0] a);
        int slot;
        if (m_present(a)) return;
        slot = -1;
        for (int i = 0; i < NE; i++) begin
            if (!m_vld[i] && slot < 0) slot = i;
        end
        if (slot < 0) begin
            slot = m_victim;
            m_victim = (m_victim + 1) % NE;
        end
        m_vld[slot] = 1'b1;
        m_tag[slot] = a;
    endfunction

    // ---------------- driver ----------------
    // One clock cycle: drive, check gnt, advance the model, then check the
    // response and counters produced by the edge.
    task automatic step(input bit req, input bit we, input bit flush,
                        input bit rst_n, input logic [AW-1:0] addr);
        logic [1:0] exp;
        bit hit;
        rst_ni             = rst_n;
        plb_cache_mem_req  = req;
        plb_cache_mem_we   = we;
        plb_flush_i        = flush;
        plb_cache_mem_addr = addr;
        #2;
        check_val("gnt", {31'd0, plb_cache_mem_gnt}, {31'd0, req && !flush});

        exp = 2'b00;
        if (!rst_n) begin
            m_clear();
            m_hits = 0;
            m_miss = 0;
        end else if (flush) begin
            m_clear();
        end else if (req) begin
            if (!we) begin
                hit = m_present(addr);
                exp = {1'b1, hit};
                if (hit) m_hits = (m_hits < CNT_MAX) ? m_hits + 1 : CNT_MAX;
                else     m_miss = (m_miss < CNT_MAX) ? m_miss + 1 : CNT_MAX;
            end else begin
                exp = 2'b10;
                m_insert(addr);
            end
        end
        exp_q.push_back(exp);

        @(posedge clk_i);
        #1;
        exp = exp_q.pop_front();
        check_val("valid", {31'd0, plb_cache_mem_valid}, {31'd0, exp[1]});
        check_val("rdata", {31'd0, plb_cache_mem_rdata}, {31'd0, exp[0]});
        check_val("hit_count",  {28'd0, plb_hit_count_o},  32'(m_hits));
        check_val("miss_count", {28'd0, plb_miss_count_o}, 32'(m_miss));
    endtask

    task automatic lookup(input logic [AW-1:0] a); step(1, 0, 0, 1, a); endtask
    task automatic insert(input logic [AW-1:0] a); step(1, 1, 0, 1, a); endtask
    task automatic idle();                        step(0, 0, 0, 1, '0); endtask

    // ---------------- stimulus ----------------
    initial begin
        m_clear();
        m_hits = 0;
        m_miss = 0;

        // Reset state
        step(0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 32'h1234);
        idle();

        // First lookup misses; insert then hit; neighbour misses
        lookup(32'h1234);
        insert(32'h1234);
        lookup(32'h1234);
        lookup(32'h1235);

        // Flush empties the store
        step(1, 0, 1, 1, 32'h1234);
        lookup(32'h1234);

        // Fill, then round-robin eviction A0 then A1
        for (int i = 0; i < NE; i++) insert(32'hA000_0000 + i);
        insert(32'hA000_0008);
        lookup(32'hA000_0000);
        lookup(32'hA000_0008);
        insert(32'hA000_0009);
        lookup(32'hA000_0001);
        lookup(32'hA000_0009);
        lookup(32'hA000_0002);

        // In-flight hit completes across a flush; flush blocks the grant
        lookup(32'hA000_0008);
        step(1, 0, 1, 1, 32'hA000_0008);
        lookup(32'hA000_0008);

        // Duplicate insert does not consume a slot
        insert(32'hB000_0000);
        insert(32'hB000_0000);
        for (int i = 1; i < NE; i++) insert(32'hB000_0000 + i);
        for (int i = 0; i < NE; i++) lookup(32'hB000_0000 + i);

        // Hit counter saturates, then reset mid-burst
        for (int i = 0; i < 20; i++) lookup(32'hB000_0003);
        step(1, 0, 0, 0, 32'hB000_0003);
        lookup(32'hB000_0003);
        insert(32'hB000_0003);
        lookup(32'hB000_0003);

        // Randomized traffic over a small address pool
        for (int n = 0; n < 3000; n++) begin
            bit r_req, r_we, r_fl, r_rst;
            logic [AW-1:0] r_addr;
            r_req  = ($urandom_range(0, 99) < 85);
            r_we   = ($urandom_range(0, 99) < 40);
            r_fl   = ($urandom_range(0, 99) < 3);
            r_rst  = ($urandom_range(0, 199) != 0);
            r_addr = 32'hC000_0000 + 32'($urandom_range(0, 13));
            step(r_req, r_we, r_fl, r_rst, r_addr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
